fwd_scoreboard: RTL and testbench

//  Parametrised register-forwarding and hazard unit for the Y86 pipeline, placed between decode and execute.

---
 rtl/fwd_scoreboard_if.sv | 56 +++++
 rtl/fwd_scoreboard.sv | 187 ++++++++++++++++++
 tb/tb_fwd_scoreboard.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : fwd_scoreboard_if
// Description : Decode/execute/memory/writeback bundle for fwd_scoreboard.
//               master = pipeline side that drives issue and result data,
//               slave  = forwarding unit.
//   issue      : iss_valid, iss_dstE/M, iss_srcA/B, rf_valA/B, flush
//   results    : exe_valE(_vld), mem_valM(_vld)
//   outputs    : fwd_valA/B, iss_stall, wb_en/dst/val E/M, stall_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface fwd_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 16
);
  logic              iss_valid;
  logic [IDX_W-1:0]  iss_dstE;
  logic [IDX_W-1:0]  iss_dstM;
  logic [IDX_W-1:0]  iss_srcA;
  logic [IDX_W-1:0]  iss_srcB;
  logic [DATA_W-1:0] rf_valA;
  logic [DATA_W-1:0] rf_valB;
  logic              flush;
  logic [DATA_W-1:0] exe_valE;
  logic              exe_valE_vld;
  logic [DATA_W-1:0] mem_valM;
  logic              mem_valM_vld;
  logic [DATA_W-1:0] fwd_valA;
  logic [DATA_W-1:0] fwd_valB;
  logic              iss_stall;
  logic              wb_enE;
  logic              wb_enM;
  logic [IDX_W-1:0]  wb_dstE;
  logic [IDX_W-1:0]  wb_dstM;
  logic [DATA_W-1:0] wb_valE;
  logic [DATA_W-1:0] wb_valM;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output iss_valid, iss_dstE, iss_dstM, iss_srcA, iss_srcB,
           rf_valA, rf_valB, flush, exe_valE, exe_valE_vld,
           mem_valM, mem_valM_vld,
    input  fwd_valA, fwd_valB, iss_stall, wb_enE, wb_enM,
           wb_dstE, wb_dstM, wb_valE, wb_valM, stall_cnt
  );

  modport slave (
    input  iss_valid, iss_dstE, iss_dstM, iss_srcA, iss_srcB,
           rf_valA, rf_valB, flush, exe_valE, exe_valE_vld,
           mem_valM, mem_valM_vld,
    output fwd_valA, fwd_valB, iss_stall, wb_enE, wb_enM,
           wb_dstE, wb_dstM, wb_valE, wb_valM, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : fwd_scoreboard
// Description : Register forwarding / hazard unit between decode and execute.
//               A DEPTH-slot shift line tracks in-flight dstE/dstM; the
//               youngest ready match is forwarded to srcA/srcB, unresolved
//               matches stall issue, and the last slot drives writeback.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fwd_scoreboard_if.slave (issue, results, forward, writeback)
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_scoreboard #(
  parameter int               DATA_W   = 32,
  parameter int               IDX_W    = 4,
  parameter logic [IDX_W-1:0] NO_REG   = {IDX_W{1'b1}},
  parameter int               DEPTH    = 3,
  parameter int               MEM_SLOT = 1,
  parameter int               CNT_W    = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  fwd_scoreboard_if.slave    bus
);

  // Slot state: slot 0 = execute ... slot DEPTH-1 = writeback
  logic              vld_q  [DEPTH];
  logic              vld_d  [DEPTH];
  logic [IDX_W-1:0]  dste_q [DEPTH];
  logic [IDX_W-1:0]  dste_d [DEPTH];
  logic [IDX_W-1:0]  dstm_q [DEPTH];
  logic [IDX_W-1:0]  dstm_d [DEPTH];
  logic [DATA_W-1:0] vale_q [DEPTH];
  logic [DATA_W-1:0] vale_d [DEPTH];
  logic              oke_q  [DEPTH];
  logic              oke_d  [DEPTH];
  logic [DATA_W-1:0] valm_q [DEPTH];
  logic [DATA_W-1:0] valm_d [DEPTH];
  logic              okm_q  [DEPTH];
  logic              okm_d  [DEPTH];

  logic              wb_ene_q, wb_ene_d, wb_enm_q, wb_enm_d;
  logic [IDX_W-1:0]  wb_dste_q, wb_dste_d, wb_dstm_q, wb_dstm_d;
  logic [DATA_W-1:0] wb_vale_q, wb_vale_d, wb_valm_q, wb_valm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Effective per-slot values: stored value, or the result arriving this cycle
  logic [DATA_W-1:0] val_e [DEPTH];
  logic [DATA_W-1:0] val_m [DEPTH];
  logic              rdy_e [DEPTH];
  logic              rdy_m [DEPTH];

  logic [DATA_W-1:0] fwd_a, fwd_b;
  logic              rdy_a, rdy_b;
  logic              stall, issue;

  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      val_e[s] = vale_q[s];
      rdy_e[s] = oke_q[s];
      val_m[s] = valm_q[s];
      rdy_m[s] = okm_q[s];
    end
    if (bus.exe_valE_vld) begin
      val_e[0] = bus.exe_valE;
      rdy_e[0] = 1'b1;
    end
    if (bus.mem_valM_vld) begin
      val_m[MEM_SLOT] = bus.mem_valM;
      rdy_m[MEM_SLOT] = 1'b1;
    end
  end

  // Oldest slot first so younger matches overwrite; within a slot dstM is
  // applied after dstE so it wins (popl %esp writes both to the same reg).
  always_comb begin
    fwd_a = bus.rf_valA;
    rdy_a = 1'b1;
    fwd_b = bus.rf_valB;
    rdy_b = 1'b1;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (vld_q[s] && bus.iss_srcA != NO_REG) begin
        if (dste_q[s] == bus.iss_srcA) begin
          fwd_a = val_e[s];
          rdy_a = rdy_e[s];
        end
        if (dstm_q[s] == bus.iss_srcA) begin
          fwd_a = val_m[s];
          rdy_a = rdy_m[s];
        end
      end
      if (vld_q[s] && bus.iss_srcB != NO_REG) begin
        if (dste_q[s] == bus.iss_srcB) begin
          fwd_b = val_e[s];
          rdy_b = rdy_e[s];
        end
        if (dstm_q[s] == bus.iss_srcB) begin
          fwd_b = val_m[s];
          rdy_b = rdy_m[s];
        end
      end
    end
  end

  assign stall = bus.iss_valid & ~bus.flush & ~(rdy_a & rdy_b);
  assign issue = bus.iss_valid & ~bus.flush & ~stall;

  always_comb begin
    // Slot 0 takes the new instruction or a bubble
    vld_d[0]  = issue;
    dste_d[0] = issue ? bus.iss_dstE : NO_REG;
    dstm_d[0] = issue ? bus.iss_dstM : NO_REG;
    vale_d[0] = '0;
    oke_d[0]  = 1'b0;
    valm_d[0] = '0;
    okm_d[0]  = 1'b0;
    // Older slots always advance; results arriving this cycle are captured
    for (int s = 1; s < DEPTH; s++) begin
      vld_d[s]  = vld_q[s-1];
      dste_d[s] = dste_q[s-1];
      dstm_d[s] = dstm_q[s-1];
      vale_d[s] = val_e[s-1];
      oke_d[s]  = rdy_e[s-1];
      valm_d[s] = val_m[s-1];
      okm_d[s]  = rdy_m[s-1];
    end
    wb_ene_d  = vld_q[DEPTH-1] & (dste_q[DEPTH-1] != NO_REG);
    wb_enm_d  = vld_q[DEPTH-1] & (dstm_q[DEPTH-1] != NO_REG);
    wb_dste_d = dste_q[DEPTH-1];
    wb_dstm_d = dstm_q[DEPTH-1];
    wb_vale_d = val_e[DEPTH-1];
    wb_valm_d = val_m[DEPTH-1];
    cnt_d     = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        vld_q[s]  <= 1'b0;
        dste_q[s] <= NO_REG;
        dstm_q[s] <= NO_REG;
        vale_q[s] <= '0;
        oke_q[s]  <= 1'b0;
        valm_q[s] <= '0;
        okm_q[s]  <= 1'b0;
      end
      wb_ene_q  <= 1'b0;
      wb_enm_q  <= 1'b0;
      wb_dste_q <= '0;
      wb_dstm_q <= '0;
      wb_vale_q <= '0;
      wb_valm_q <= '0;
      cnt_q     <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        vld_q[s]  <= vld_d[s];
        dste_q[s] <= dste_d[s];
        dstm_q[s] <= dstm_d[s];
        vale_q[s] <= vale_d[s];
        oke_q[s]  <= oke_d[s];
        valm_q[s] <= valm_d[s];
        okm_q[s]  <= okm_d[s];
      end
      wb_ene_q  <= wb_ene_d;
      wb_enm_q  <= wb_enm_d;
      wb_dste_q <= wb_dste_d;
      wb_dstm_q <= wb_dstm_d;
      wb_vale_q <= wb_vale_d;
      wb_valm_q <= wb_valm_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.fwd_valA  = fwd_a;
  assign bus.fwd_valB  = fwd_b;
  assign bus.iss_stall = stall;
  assign bus.wb_enE    = wb_ene_q;
  assign bus.wb_enM    = wb_enm_q;
  assign bus.wb_dstE   = wb_dste_q;
  assign bus.wb_dstM   = wb_dstm_q;
  assign bus.wb_valE   = wb_vale_q;
  assign bus.wb_valM   = wb_valm_q;
  assign bus.stall_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_scoreboard
// Description : Directed self-checking bench for fwd_scoreboard
//               (DEPTH=3, MEM_SLOT=1, CNT_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_scoreboard;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = 4;
  localparam int DEPTH    = 3;
  localparam int MEM_SLOT = 1;
  localparam int CNT_W    = 8;
  localparam logic [IDX_W-1:0] NR = 4'hF;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fwd_scoreboard_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  fwd_scoreboard #(
    .DATA_W(DATA_W), .IDX_W(IDX_W), .NO_REG(NR),
    .DEPTH(DEPTH), .MEM_SLOT(MEM_SLOT), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic idle();
    bus.iss_valid    = 1'b0;
    bus.iss_dstE     = NR;
    bus.iss_dstM     = NR;
    bus.iss_srcA     = NR;
    bus.iss_srcB     = NR;
    bus.rf_valA      = 32'hAAAA_0000;
    bus.rf_valB      = 32'hBBBB_0000;
    bus.flush        = 1'b0;
    bus.exe_valE     = '0;
    bus.exe_valE_vld = 1'b0;
    bus.mem_valM     = '0;
    bus.mem_valM_vld = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic issue(input logic [3:0] de, input logic [3:0] dm,
                       input logic [3:0] sa, input logic [3:0] sb);
    bus.iss_valid = 1'b1;
    bus.iss_dstE  = de;
    bus.iss_dstM  = dm;
    bus.iss_srcA  = sa;
    bus.iss_srcB  = sb;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (bus.wb_enE !== 1'b0) begin n_fail++; $display("FAIL rst_wb_enE: got %b want 0", bus.wb_enE); end
    n_cmp++; if (bus.wb_enM !== 1'b0) begin n_fail++; $display("FAIL rst_wb_enM: got %b want 0", bus.wb_enM); end
    n_cmp++; if (bus.stall_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_cnt: got %h want 00", bus.stall_cnt); end
    n_cmp++; if (bus.fwd_valA !== 32'hAAAA_0000) begin n_fail++; $display("FAIL rst_fwdA: got %h want aaaa0000", bus.fwd_valA); end
  endtask

  // irmovl $5,%eax ; addl %eax,%ebx
  task automatic test_exec_fwd();
    do_reset();
    issue(4'h0, NR, NR, NR);
    #1;
    n_cmp++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL t1_stall0: got %b want 0", bus.iss_stall); end
    tick();
    issue(4'h3, NR, 4'h0, 4'h3);
    bus.exe_valE = 32'd5; bus.exe_valE_vld = 1'b1;
    #1;
    n_cmp++; if (bus.fwd_valA !== 32'd5) begin n_fail++; $display("FAIL t1_fwdA: got %h want 5", bus.fwd_valA); end
    n_cmp++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL t1_stall1: got %b want 0", bus.iss_stall); end
    n_cmp++; if (bus.fwd_valB !== 32'hBBBB_0000) begin n_fail++; $display("FAIL t1_fwdB_rf: got %h want bbbb0000", bus.fwd_valB); end
    tick();
    idle(); bus.exe_valE = 32'h105; bus.exe_valE_vld = 1'b1;
    tick();
    idle();
    tick();
    n_cmp++; if ({bus.wb_enE, bus.wb_dstE, bus.wb_valE, bus.wb_enM} !== {1'b1, 4'h0, 32'd5, 1'b0})
      begin n_fail++; $display("FAIL t1_wb0: got en=%b dst=%h val=%h enM=%b want 1/0/5/0", bus.wb_enE, bus.wb_dstE, bus.wb_valE, bus.wb_enM); end
    tick();
    n_cmp++; if ({bus.wb_enE, bus.wb_dstE, bus.wb_valE} !== {1'b1, 4'h3, 32'h105})
      begin n_fail++; $display("FAIL t1_wb1: got en=%b dst=%h val=%h want 1/3/105", bus.wb_enE, bus.wb_dstE, bus.wb_valE); end
  endtask

  // mrmovl (..),%eax ; addl %eax,%ecx
  task automatic test_load_use();
    do_reset();
    issue(NR, 4'h0, NR, 4'h5);
    tick();
    issue(4'h1, NR, 4'h0, 4'h1);
    #1;
    n_cmp++; if (bus.iss_stall !== 1'b1) begin n_fail++; $display("FAIL t2_stall: got %b want 1", bus.iss_stall); end
    tick();
    bus.mem_valM = 32'h1234; bus.mem_valM_vld = 1'b1;
    #1;
    n_cmp++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL t2_release: got %b want 0", bus.iss_stall); end
    n_cmp++; if (bus.fwd_valA !== 32'h1234) begin n_fail++; $display("FAIL t2_fwdA: got %h want 1234", bus.fwd_valA); end
    n_cmp++; if (bus.stall_cnt !== 8'd1) begin n_fail++; $display("FAIL t2_cnt: got %h want 01", bus.stall_cnt); end
    tick();
    idle(); bus.exe_valE = 32'h99; bus.exe_valE_vld = 1'b1;
    tick();
    idle();
    n_cmp++; if ({bus.wb_enM, bus.wb_dstM, bus.wb_valM, bus.wb_enE} !== {1'b1, 4'h0, 32'h1234, 1'b0})
      begin n_fail++; $display("FAIL t2_wbM: got en=%b dst=%h val=%h enE=%b want 1/0/1234/0", bus.wb_enM, bus.wb_dstM, bus.wb_valM, bus.wb_enE); end
    n_cmp++; if (bus.stall_cnt !== 8'd1) begin n_fail++; $display("FAIL t2_cnt_hold: got %h want 01", bus.stall_cnt); end
  endtask

  // popl %esp ; read %esp
  task automatic test_popl();
    do_reset();
    issue(4'h4, 4'h4, 4'h4, 4'h4);
    tick();
    issue(4'h0, NR, 4'h4, NR);
    bus.exe_valE = 32'h100; bus.exe_valE_vld = 1'b1;
    #1;
    n_cmp++; if (bus.iss_stall !== 1'b1) begin n_fail++; $display("FAIL t3_stall: got %b want 1", bus.iss_stall); end
    tick();
    bus.exe_valE_vld = 1'b0;
    bus.mem_valM = 32'h200; bus.mem_valM_vld = 1'b1;
    #1;
    n_cmp++; if (bus.fwd_valA !== 32'h200) begin n_fail++; $display("FAIL t3_fwdA: got %h want 200", bus.fwd_valA); end
    n_cmp++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL t3_nostall: got %b want 0", bus.iss_stall); end
    tick();
    idle(); bus.exe_valE = 32'h7; bus.exe_valE_vld = 1'b1;
    tick();
    idle();
    n_cmp++; if ({bus.wb_enE, bus.wb_valE, bus.wb_enM, bus.wb_valM} !== {1'b1, 32'h100, 1'b1, 32'h200})
      begin n_fail++; $display("FAIL t3_wb: got E=%b/%h M=%b/%h want 1/100 1/200", bus.wb_enE, bus.wb_valE, bus.wb_enM, bus.wb_valM); end
  endtask

  // %edx written by slot 2 (9) and slot 0 (7); NO_REG sources
  task automatic test_priority();
    do_reset();
    issue(4'h2, NR, NR, NR);
    tick();
    idle(); bus.exe_valE = 32'd9; bus.exe_valE_vld = 1'b1;
    tick();
    idle(); issue(4'h2, NR, NR, NR);
    tick();
    issue(4'h6, NR, 4'h2, NR);
    bus.rf_valB = 32'hBEEF; bus.exe_valE = 32'd7; bus.exe_valE_vld = 1'b1;
    #1;
    n_cmp++; if (bus.fwd_valA !== 32'd7) begin n_fail++; $display("FAIL t4_young: got %h want 7", bus.fwd_valA); end
    n_cmp++; if (bus.fwd_valB !== 32'hBEEF) begin n_fail++; $display("FAIL t4_noreg_B: got %h want beef", bus.fwd_valB); end
    tick();
    issue(NR, NR, NR, 4'h2);
    bus.rf_valA = 32'h5555; bus.exe_valE = 32'h1; bus.exe_valE_vld = 1'b1;
    #1;
    n_cmp++; if (bus.fwd_valA !== 32'h5555) begin n_fail++; $display("FAIL t4_noreg_A: got %h want 5555", bus.fwd_valA); end
    n_cmp++; if (bus.fwd_valB !== 32'd7) begin n_fail++; $display("FAIL t4_slot1: got %h want 7", bus.fwd_valB); end
    tick();
    idle(); bus.iss_srcA = 4'h2;
    #1;
    n_cmp++; if (bus.fwd_valA !== 32'd7) begin n_fail++; $display("FAIL t4_wbslot: got %h want 7", bus.fwd_valA); end
  endtask

  task automatic test_flush();
    do_reset();
    issue(NR, 4'h3, NR, NR);
    tick();
    issue(4'h6, NR, 4'h3, NR);
    bus.flush = 1'b1;
    #1;
    n_cmp++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL t5_flush_stall: got %b want 0", bus.iss_stall); end
    tick();
    idle(); bus.iss_srcA = 4'h6;
    #1;
    n_cmp++; if (bus.fwd_valA !== 32'hAAAA_0000) begin n_fail++; $display("FAIL t5_no_fwd: got %h want aaaa0000", bus.fwd_valA); end
    for (int k = 0; k < DEPTH + 1; k++) begin
      tick();
      n_cmp++; if (bus.wb_enE !== 1'b0) begin n_fail++; $display("FAIL t5_wbE[%0d]: got %b want 0", k, bus.wb_enE); end
    end
  endtask

  // Load chain on %ecx: issue / stall x3 repeating until the counter saturates,
  // then reset in the middle of it.
  task automatic test_stall_sat_reset();
    int stalls;
    logic exp;
    do_reset();
    stalls = 0;
    for (int i = 0; i < 348; i++) begin
      issue(NR, 4'h1, 4'h1, NR);
      exp = ((i % 4) != 0);
      #1;
      n_cmp++; if (bus.iss_stall !== exp) begin n_fail++; $display("FAIL t6_stall[%0d]: got %b want %b", i, bus.iss_stall, exp); end
      if (exp) stalls++;
      tick();
      if (i == 3) begin
        n_cmp++; if (bus.stall_cnt !== 8'd3) begin n_fail++; $display("FAIL t6_cnt3: got %h want 03", bus.stall_cnt); end
      end
    end
    n_cmp++; if (stalls < 259) begin n_fail++; $display("FAIL t6_stall_total: got %0d want >=259", stalls); end
    n_cmp++; if (bus.stall_cnt !== 8'hFF) begin n_fail++; $display("FAIL t6_sat: got %h want ff", bus.stall_cnt); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if ({bus.wb_enE, bus.wb_enM, bus.wb_dstM, bus.wb_valM, bus.stall_cnt} !== {1'b0, 1'b0, 4'h0, 32'h0, 8'h0})
      begin n_fail++; $display("FAIL t6_rst_wb: got enE=%b enM=%b dstM=%h valM=%h cnt=%h want all 0", bus.wb_enE, bus.wb_enM, bus.wb_dstM, bus.wb_valM, bus.stall_cnt); end
    issue(NR, NR, 4'h1, NR);
    bus.rf_valA = 32'hABCD;
    #1;
    n_cmp++; if (bus.fwd_valA !== 32'hABCD) begin n_fail++; $display("FAIL t6_rst_fwd: got %h want abcd", bus.fwd_valA); end
    n_cmp++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL t6_rst_stall: got %b want 0", bus.iss_stall); end
    for (int k = 0; k < DEPTH + 1; k++) begin
      tick();
      idle();
      n_cmp++; if (bus.wb_enM !== 1'b0) begin n_fail++; $display("FAIL t6_rst_wbM[%0d]: got %b want 0", k, bus.wb_enM); end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_exec_fwd();
    test_load_use();
    test_popl();
    test_priority();
    test_flush();
    test_stall_sat_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
